// File: rtl/dmem_sram_responder_pkg.sv
// Shared types and defaults for the data-SRAM responder.
package dmem_sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W          = 4;
  localparam int NUM_LANES      = 4;
  localparam int LANE_W         = 8;
  localparam int DEF_DEPTH_LOG2 = 12;
  localparam int DEF_LATENCY    = 2;

endpackage

// File: rtl/dmem_sram_responder_array.sv
// Single-port synchronous word RAM built from independent byte lanes.
// An enabled cycle with any lane enable set is a write; with none set it is a read.
module dmem_array
  import dmem_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic rd_en;
  assign rd_en = en & ~(|we);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;

    // Byte-lane storage: write the lane when enabled, or capture it on a read.
    always_ff @(posedge clk) begin
      if (en && we[l]) mem[idx] <= wdata[l*LANE_W +: LANE_W];
      if (rd_en)       rd_q     <= mem[idx];
    end

    assign rdata[l*LANE_W +: LANE_W] = rd_q;
  end

endmodule

// File: rtl/dmem_sram_responder.sv
// Responder end of the MEM-stage data-SRAM interface: one outstanding
// request, fixed programmable wait states, single-cycle data_ok pulse.
module dmem_sram_responder
  import dmem_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy
);

  // Counter preload so that WAIT lasts LATENCY-1 cycles before RESP.
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_wr_q, pend_wr_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    accept;
  logic                    arr_en;
  logic [3:0]              arr_we;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             arr_rdata;
  logic [31:0]             resp_word;
  logic                    unused_addr;

  assign addr_ok = (state_q == ST_IDLE) | (state_q == ST_RESP);
  assign accept  = req & addr_ok;
  // No accept is honoured on a reset edge, so the array is left alone too.
  assign arr_en  = accept & resetn;
  assign arr_we  = wr ? wstrb : 4'b0000;
  assign idx     = addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .idx   (idx),
    .wdata (wdata),
    .rdata (arr_rdata)
  );

  // The array output register is the read holding register; it only moves on
  // an accept, so it stays stable through WAIT and RESP.
  assign resp_word = pend_wr_q ? 32'h0 : arr_rdata;
  assign data_ok   = (state_q == ST_RESP);
  assign rdata     = data_ok ? resp_word : rdata_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state: wait-state countdown, response retire, and new accepts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_wr_d = pend_wr_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        rdata_d = resp_word;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      pend_wr_d = wr;
      if (LATENCY == 1) begin
        state_d = ST_RESP;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
      end
    end
  end

  // State registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_wr_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_wr_q <= pend_wr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: three instances with different depth/latency,
// a word-level reference memory and cycle-count latency expectations.
module tb_dmem_sram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        rq  [3];
  logic        aok [3];
  logic        dok [3];
  logic        bsy [3];
  logic [31:0] rdt [3];

  int errors = 0;
  int checks = 0;

  // Reference memory: key = instance*2^20 + word index.
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  // Instance 0: defaults (depth 2^12, latency 2)
  dmem_sram_responder u_d0 (
    .clk(clk), .resetn(resetn), .req(rq[0]), .wr(wr), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rdt[0]), .busy(bsy[0]));
  // Instance 1: depth 2^4, latency 1
  dmem_sram_responder #(.DEPTH_LOG2(4), .LATENCY(1)) u_d1 (
    .clk(clk), .resetn(resetn), .req(rq[1]), .wr(wr), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rdt[1]), .busy(bsy[1]));
  // Instance 2: depth 2^6, latency 4
  dmem_sram_responder #(.DEPTH_LOG2(6), .LATENCY(4)) u_d2 (
    .clk(clk), .resetn(resetn), .req(rq[2]), .wr(wr), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rdt[2]), .busy(bsy[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? 12 : (d == 1) ? 4 : 6;
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) & ((32'd1 << dep_of(d)) - 32'd1);
    return d * (1 << 20) + int'(w);
  endfunction

  function automatic logic [31:0] mdl_rd(input int d, input logic [31:0] a);
    int k;
    k = key(d, a);
    return mdl.exists(k) ? mdl[k] : 32'h0;
  endfunction

  task automatic mdl_wr(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
    logic [31:0] cur;
    cur = mdl_rd(d, a);
    for (int l = 0; l < 4; l++) if (s[l]) cur[l*8 +: 8] = wd[l*8 +: 8];
    mdl[key(d, a)] = cur;
  endtask

  // Driver: issue one request (called just after a posedge), return the number
  // of cycles from accept edge to data_ok (-1 on timeout), the rdata seen then,
  // and how many waiting cycles had busy low. Returns just after a posedge.
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output int busy_lo);
    int n;
    lat = -1; rd = '0; busy_lo = 0; n = 0;
    wr = w; addr = a; wstrb = s; wdata = wd; rq[d] = 1'b1;
    while (!aok[d] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    rq[d] = 1'b0;
    wr = $urandom_range(0, 1); addr = $urandom; wstrb = 4'($urandom); wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bsy[d]) busy_lo++;
      if (dok[d]) begin lat = c; rd = rdt[d]; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) rq[d] = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (dok[d] !== 1'b0) begin errors++; $display("FAIL reset_data_ok d%0d got %b want 0", d, dok[d]); end
      checks++; if (rdt[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata d%0d got %h want 0", d, rdt[d]); end
      checks++; if (bsy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d%0d got %b want 0", d, bsy[d]); end
      checks++; if (aok[d] !== 1'b1) begin errors++; $display("FAIL reset_addr_ok d%0d got %b want 1", d, aok[d]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat, bl; logic [31:0] rd;
    xact(0, 1'b1, 32'h10, 4'hF, 32'h12345678, lat, rd, bl);
    mdl_wr(0, 32'h10, 4'hF, 32'h12345678);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", rd); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL wr_busy_low got %0d want 0", bl); end
    xact(0, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, bl);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_data got %h want 12345678", rd); end
    // rdata holds its value after data_ok drops
    @(negedge clk);
    checks++; if (rdt[0] !== 32'h12345678 || dok[0] !== 1'b0) begin
      errors++; $display("FAIL rdata_hold got %h/%b want 12345678/0", rdt[0], dok[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_lanes();
    int lat, bl; logic [31:0] rd;
    xact(0, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, lat, rd, bl);
    mdl_wr(0, 32'h20, 4'hF, 32'hAABBCCDD);
    xact(0, 1'b1, 32'h20, 4'b0101, 32'h11223344, lat, rd, bl);
    mdl_wr(0, 32'h20, 4'b0101, 32'h11223344);
    xact(0, 1'b0, 32'h20, 4'h0, 32'h0, lat, rd, bl);
    checks++; if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL byte_lanes got %h want aa22cc44", rd); end
    checks++; if (rd !== mdl_rd(0, 32'h20)) begin errors++; $display("FAIL byte_lanes_model got %h want %h", rd, mdl_rd(0, 32'h20)); end
    // wstrb=0 write changes nothing but still completes
    xact(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, lat, rd, bl);
    checks++; if (lat !== 2) begin errors++; $display("FAIL noop_wr_latency got %0d want 2", lat); end
    xact(0, 1'b0, 32'h23, 4'h0, 32'h0, lat, rd, bl);
    checks++; if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL noop_wr_data got %h want aa22cc44", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, bl; logic [31:0] rd; logic [31:0] exp_q [4];
    for (int k = 0; k < 4; k++) begin
      exp_q[k] = $urandom;
      xact(1, 1'b1, 32'(k * 4), 4'hF, exp_q[k], lat, rd, bl);
      mdl_wr(1, 32'(k * 4), 4'hF, exp_q[k]);
      checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_wr_latency k%0d got %0d want 1", k, lat); end
    end
    wr = 1'b0; addr = 32'h0; rq[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (aok[1] !== 1'b1) begin errors++; $display("FAIL b2b_addr_ok k%0d got %b want 1", k, aok[1]); end
      if (k > 0) begin
        checks++; if (dok[1] !== 1'b1 || rdt[1] !== mdl_rd(1, 32'((k - 1) * 4))) begin
          errors++; $display("FAIL b2b_data k%0d got %b/%h want 1/%h", k, dok[1], rdt[1], mdl_rd(1, 32'((k - 1) * 4))); end
      end
      @(posedge clk); #1;
      addr = 32'((k + 1) * 4);
    end
    rq[1] = 1'b0;
    @(negedge clk);
    checks++; if (dok[1] !== 1'b1 || rdt[1] !== mdl_rd(1, 32'hC)) begin
      errors++; $display("FAIL b2b_last got %b/%h want 1/%h", dok[1], rdt[1], mdl_rd(1, 32'hC)); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dok[1] !== 1'b0 || bsy[1] !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got %b/%b want 0/0", dok[1], bsy[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int lat, bl; logic [31:0] rd;
    xact(1, 1'b1, 32'h40, 4'hF, 32'h5A5A5A5A, lat, rd, bl);
    mdl_wr(1, 32'h40, 4'hF, 32'h5A5A5A5A);
    xact(1, 1'b0, 32'h00, 4'h0, 32'h0, lat, rd, bl);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL wrap got %h want 5a5a5a5a", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, bl, seen; logic [31:0] rd;
    // read accepted at edge N, reset at edge N+2
    wr = 1'b0; addr = 32'h8; rq[2] = 1'b1;
    @(posedge clk); #1 rq[2] = 1'b0;
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    seen = 0;
    @(negedge clk);
    checks++; if (bsy[2] !== 1'b0 || aok[2] !== 1'b1 || rdt[2] !== 32'h0) begin
      errors++; $display("FAIL mid_reset_state got busy=%b addr_ok=%b rdata=%h want 0/1/0", bsy[2], aok[2], rdt[2]); end
    for (int c = 0; c < 8; c++) begin
      if (dok[2]) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_data_ok got %0d pulses want 0", seen); end
    @(posedge clk); #1;
    // write accepted before the reset edge stays committed
    wr = 1'b1; addr = 32'h10; wstrb = 4'hF; wdata = 32'hC0FFEE01; rq[2] = 1'b1;
    @(posedge clk); #1 rq[2] = 1'b0;
    mdl_wr(2, 32'h10, 4'hF, 32'hC0FFEE01);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    xact(2, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, bl);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_reset_rd_latency got %0d want 4", lat); end
    checks++; if (rd !== 32'hC0FFEE01) begin errors++; $display("FAIL mid_reset_commit got %h want c0ffee01", rd); end
  endtask

  task automatic test_random();
    int lat, bl; logic [31:0] rd, a, wd, exp; logic w; logic [3:0] s;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      xact(0, 1'b1, 32'(i * 4 + 32'h100), 4'hF, wd, lat, rd, bl);
      mdl_wr(0, 32'(i * 4 + 32'h100), 4'hF, wd);
    end
    for (int i = 0; i < 60; i++) begin
      a  = ($urandom & 32'hFFFF_C003) | 32'h100 | (32'($urandom_range(0, 7)) << 2);
      w  = 1'($urandom_range(0, 1));
      s  = 4'($urandom);
      wd = $urandom;
      exp = w ? 32'h0 : mdl_rd(0, a);
      xact(0, w, a, s, wd, lat, rd, bl);
      if (w) mdl_wr(0, a, s, wd);
      checks++; if (lat !== lat_of(0) || rd !== exp || bl !== 0) begin
        errors++; $display("FAIL rand_%0d wr=%b a=%h got lat=%0d rd=%h busy_lo=%0d want lat=%0d rd=%h busy_lo=0",
                           i, w, a, lat, rd, bl, lat_of(0), exp); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) rq[d] = 1'b0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
